// File: rtl/cpu_mem_pkg.sv
// Shared types and defaults for the CPU memory-side port: FSM state encoding,
// bus/address widths, and the meaning of the mem_we command bit.
// No logic here; consumed by mdr_mem_port and its interface.
package cpu_mem_pkg;

  localparam int CPU_DATA_W      = 32;
  localparam int CPU_ADDR_W      = 9;
  localparam int CPU_MEM_TIMEOUT = 15;

  // mem_we encoding while mem_req is high
  localparam logic MEM_CMD_READ  = 1'b0;
  localparam logic MEM_CMD_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

endpackage

// File: rtl/mdr_mem_port_if.sv
// Bundles the datapath-bus side, the memory req/ack side and the status flags.
// slave = the MAR/MDR port itself, master = the CPU datapath plus memory model.
// Purely wiring; no latency or backpressure of its own.
interface mdr_mem_port_if
  import cpu_mem_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W
);

  // datapath bus side
  logic [DATA_W-1:0] BusMuxOut;
  logic              MARin;
  logic              MDRin;
  logic              rd_go;
  logic              wr_go;
  logic [DATA_W-1:0] BusMuxIn_MDR;

  // memory side
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  // status
  logic              busy;
  logic              done;
  logic              err;

  modport slave (
    input  BusMuxOut, MARin, MDRin, rd_go, wr_go, mem_rdata, mem_ack,
    output BusMuxIn_MDR, mem_addr, mem_wdata, mem_req, mem_we, busy, done, err
  );

  modport master (
    output BusMuxOut, MARin, MDRin, rd_go, wr_go, mem_rdata, mem_ack,
    input  BusMuxIn_MDR, mem_addr, mem_wdata, mem_req, mem_we, busy, done, err
  );

endinterface

// File: rtl/mem_timeout_ctr.sv
// Counts cycles spent waiting for mem_ack; tc_o flags the TIMEOUT-th waiting cycle.
// Latency: tc_o is combinational from the count and en_i (same cycle).
// No backpressure; start_i clears, en_i advances.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic clr,
  input  logic start_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int            CW     = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Clear on a new transfer, otherwise count each enabled (REQ) cycle
  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Count holds k-1 during the k-th REQ cycle, so this fires on the TIMEOUT-th one
  assign tc_o = en_i && (cnt_q == TC_VAL);

endmodule

// File: rtl/mdr_mem_port.sv
// Memory-side MAR/MDR endpoint: bus loads, req/ack read/write to memory, timeout abort.
// Latency: go at edge n -> mem_req in cycle n+1; fastest transfer is 3 cycles go->IDLE.
// Memory stalls via mem_ack; go pulses outside IDLE are dropped, not queued.
module mdr_mem_port
  import cpu_mem_pkg::*;
#(
  parameter int DATA_W  = CPU_DATA_W,
  parameter int ADDR_W  = CPU_ADDR_W,
  parameter int TIMEOUT = CPU_MEM_TIMEOUT
) (
  input  logic          clk,
  input  logic          clr,
  mdr_mem_port_if.slave bus
);

  state_e            state_q;
  state_e            state_d;
  logic [ADDR_W-1:0] mar_q;
  logic [ADDR_W-1:0] mar_d;
  logic [DATA_W-1:0] mdr_q;
  logic [DATA_W-1:0] mdr_d;
  logic              we_q;
  logic              we_d;
  logic              err_q;
  logic              err_d;

  logic idle;
  logic start_rd;
  logic start_wr;
  logic start;
  logic go_clash;
  logic any_go;
  logic tmo_tc;

  assign idle     = (state_q == ST_IDLE);
  assign any_go   = bus.rd_go || bus.wr_go;
  assign start_rd = idle && bus.rd_go && !bus.wr_go;
  assign start_wr = idle && bus.wr_go && !bus.rd_go;
  assign start    = start_rd || start_wr;
  assign go_clash = idle && bus.rd_go && bus.wr_go;

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk     (clk),
    .clr     (clr),
    .start_i (start),
    .en_i    (state_q == ST_REQ),
    .tc_o    (tmo_tc)
  );

  // State register; clr drops mem_req at once because outputs decode from it
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: ack beats a same-cycle timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_REQ;
      ST_REQ: begin
        if (bus.mem_ack) begin
          state_d = ST_DONE;
        end else if (tmo_tc) begin
          state_d = ST_ERR;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state and the held registers
  always_comb begin
    bus.mem_req      = (state_q == ST_REQ);
    bus.mem_we       = (state_q == ST_REQ) ? we_q : MEM_CMD_READ;
    bus.busy         = !idle;
    bus.done         = (state_q == ST_DONE);
    bus.err          = err_q;
    bus.mem_addr     = mar_q;
    bus.mem_wdata    = mdr_q;
    bus.BusMuxIn_MDR = mdr_q;
  end

  // Datapath next state: loads only in IDLE and not alongside a go pulse,
  // so a transfer always sees the MAR/MDR that were there before the go edge
  always_comb begin
    mar_d = mar_q;
    mdr_d = mdr_q;
    we_d  = we_q;
    err_d = err_q;
    if (idle && !any_go) begin
      if (bus.MARin) mar_d = bus.BusMuxOut[ADDR_W-1:0];
      if (bus.MDRin) mdr_d = bus.BusMuxOut;
    end
    if (start) begin
      we_d  = start_wr ? MEM_CMD_WRITE : MEM_CMD_READ;
      err_d = 1'b0;
    end
    if (go_clash) err_d = 1'b1;
    if ((state_q == ST_REQ) && bus.mem_ack && (we_q == MEM_CMD_READ)) begin
      mdr_d = bus.mem_rdata;
    end
    if (state_q == ST_ERR) err_d = 1'b1;
  end

  // MAR, MDR, command and sticky error registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      mar_q <= '0;
      mdr_q <= '0;
      we_q  <= MEM_CMD_READ;
      err_q <= 1'b0;
    end else begin
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      we_q  <= we_d;
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_mdr_mem_port.sv
// Directed bench for mdr_mem_port: write, read, timeout, boundary ack, go clash,
// bus stability while busy, and asynchronous reset mid-transfer.
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_mdr_mem_port;

  logic clk;
  logic clr;
  int   checks;
  int   failures;

  mdr_mem_port_if #(.DATA_W(32), .ADDR_W(9)) bus_if ();

  mdr_mem_port #(
    .DATA_W  (32),
    .ADDR_W  (9),
    .TIMEOUT (15)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clr                = 1'b1;
    bus_if.BusMuxOut   = '0;
    bus_if.MARin       = 1'b0;
    bus_if.MDRin       = 1'b0;
    bus_if.rd_go       = 1'b0;
    bus_if.wr_go       = 1'b0;
    bus_if.mem_rdata   = '0;
    bus_if.mem_ack     = 1'b0;
    tick();
    tick();
    chk("rst_req", 32'(bus_if.mem_req), 32'd0);
    chk("rst_busy", 32'(bus_if.busy), 32'd0);
    chk("rst_err", 32'(bus_if.err), 32'd0);
    chk("rst_mdr", bus_if.BusMuxIn_MDR, 32'h0);
    clr = 1'b0;
    tick();

    // ---- write: MAR=085, MDR=DEADBEEF, ack on 2nd REQ cycle
    bus_if.BusMuxOut = 32'h0000_0085;
    bus_if.MARin     = 1'b1;
    tick();
    bus_if.MARin     = 1'b0;
    bus_if.BusMuxOut = 32'hDEAD_BEEF;
    bus_if.MDRin     = 1'b1;
    tick();
    bus_if.MDRin = 1'b0;
    chk("ld_mar", 32'(bus_if.mem_addr), 32'h085);
    chk("ld_mdr", bus_if.BusMuxIn_MDR, 32'hDEAD_BEEF);
    bus_if.wr_go     = 1'b1;
    bus_if.mem_rdata = 32'h5555_5555;
    tick();
    bus_if.wr_go = 1'b0;
    chk("wr_req1", 32'(bus_if.mem_req), 32'd1);
    chk("wr_we1", 32'(bus_if.mem_we), 32'd1);
    chk("wr_busy", 32'(bus_if.busy), 32'd1);
    chk("wr_addr", 32'(bus_if.mem_addr), 32'h085);
    chk("wr_wdata", bus_if.mem_wdata, 32'hDEAD_BEEF);
    tick();
    chk("wr_req2", 32'(bus_if.mem_req), 32'd1);
    chk("wr_we2", 32'(bus_if.mem_we), 32'd1);
    bus_if.mem_ack = 1'b1;
    tick();
    bus_if.mem_ack = 1'b0;
    chk("wr_done", 32'(bus_if.done), 32'd1);
    chk("wr_req_dn", 32'(bus_if.mem_req), 32'd0);
    tick();
    chk("wr_done_end", 32'(bus_if.done), 32'd0);
    chk("wr_idle", 32'(bus_if.busy), 32'd0);
    chk("wr_mdr_kept", bus_if.BusMuxIn_MDR, 32'hDEAD_BEEF);

    // ---- read: ack in first REQ cycle
    bus_if.mem_rdata = 32'h1234_5678;
    bus_if.rd_go     = 1'b1;
    tick();
    bus_if.rd_go = 1'b0;
    chk("rd_req", 32'(bus_if.mem_req), 32'd1);
    chk("rd_we", 32'(bus_if.mem_we), 32'd0);
    bus_if.mem_ack = 1'b1;
    tick();
    bus_if.mem_ack = 1'b0;
    chk("rd_mdr", bus_if.BusMuxIn_MDR, 32'h1234_5678);
    chk("rd_done", 32'(bus_if.done), 32'd1);
    tick();
    chk("rd_idle3", 32'(bus_if.busy), 32'd0);
    chk("rd_done_end", 32'(bus_if.done), 32'd0);

    // ---- timeout: 15 REQ cycles, no ack
    bus_if.mem_rdata = 32'hBAD0_BAD0;
    bus_if.rd_go     = 1'b1;
    tick();
    bus_if.rd_go = 1'b0;
    for (int k = 0; k < 14; k++) tick();
    chk("to_req15", 32'(bus_if.mem_req), 32'd1);
    tick();
    chk("to_err_req", 32'(bus_if.mem_req), 32'd0);
    chk("to_err_busy", 32'(bus_if.busy), 32'd1);
    chk("to_err_done", 32'(bus_if.done), 32'd0);
    tick();
    chk("to_err", 32'(bus_if.err), 32'd1);
    chk("to_idle", 32'(bus_if.busy), 32'd0);
    chk("to_mdr", bus_if.BusMuxIn_MDR, 32'h1234_5678);
    bus_if.mem_ack = 1'b1;
    tick();
    bus_if.mem_ack = 1'b0;
    chk("to_sticky", 32'(bus_if.err), 32'd1);
    chk("idle_ack_mdr", bus_if.BusMuxIn_MDR, 32'h1234_5678);
    chk("idle_ack_busy", 32'(bus_if.busy), 32'd0);
    bus_if.wr_go = 1'b1;
    tick();
    bus_if.wr_go = 1'b0;
    chk("wr_clr_err", 32'(bus_if.err), 32'd0);
    chk("wr2_we", 32'(bus_if.mem_we), 32'd1);
    bus_if.mem_ack = 1'b1;
    tick();
    bus_if.mem_ack = 1'b0;
    tick();

    // ---- boundary: ack on the 15th REQ cycle wins
    bus_if.mem_rdata = 32'hCAFE_F00D;
    bus_if.rd_go     = 1'b1;
    tick();
    bus_if.rd_go = 1'b0;
    for (int k = 0; k < 14; k++) tick();
    chk("bd_req15", 32'(bus_if.mem_req), 32'd1);
    bus_if.mem_ack = 1'b1;
    tick();
    bus_if.mem_ack = 1'b0;
    chk("bd_done", 32'(bus_if.done), 32'd1);
    chk("bd_mdr", bus_if.BusMuxIn_MDR, 32'hCAFE_F00D);
    tick();
    chk("bd_err", 32'(bus_if.err), 32'd0);
    chk("bd_idle", 32'(bus_if.busy), 32'd0);

    // ---- stability: loads and rd_go while busy are ignored
    bus_if.wr_go = 1'b1;
    tick();
    bus_if.wr_go     = 1'b0;
    bus_if.BusMuxOut = 32'hFFFF_FFFF;
    bus_if.MARin     = 1'b1;
    bus_if.MDRin     = 1'b1;
    bus_if.rd_go     = 1'b1;
    tick();
    bus_if.MARin = 1'b0;
    bus_if.MDRin = 1'b0;
    bus_if.rd_go = 1'b0;
    chk("st_addr", 32'(bus_if.mem_addr), 32'h085);
    chk("st_wdata", bus_if.mem_wdata, 32'hCAFE_F00D);
    chk("st_we", 32'(bus_if.mem_we), 32'd1);
    bus_if.mem_ack = 1'b1;
    tick();
    bus_if.mem_ack = 1'b0;
    chk("st_addr_dn", 32'(bus_if.mem_addr), 32'h085);
    chk("st_wdata_dn", bus_if.mem_wdata, 32'hCAFE_F00D);
    tick();
    tick();
    chk("st_no_2nd_req", 32'(bus_if.mem_req), 32'd0);
    chk("st_no_2nd_busy", 32'(bus_if.busy), 32'd0);

    // ---- simultaneous rd_go + wr_go
    bus_if.rd_go = 1'b1;
    bus_if.wr_go = 1'b1;
    tick();
    bus_if.rd_go = 1'b0;
    bus_if.wr_go = 1'b0;
    chk("clash_req", 32'(bus_if.mem_req), 32'd0);
    chk("clash_busy", 32'(bus_if.busy), 32'd0);
    chk("clash_err", 32'(bus_if.err), 32'd1);
    tick();
    chk("clash_req2", 32'(bus_if.mem_req), 32'd0);

    // ---- asynchronous reset mid-REQ
    bus_if.rd_go = 1'b1;
    tick();
    bus_if.rd_go = 1'b0;
    chk("ar_req", 32'(bus_if.mem_req), 32'd1);
    #2;
    clr = 1'b1;
    #1;
    chk("ar_req_drop", 32'(bus_if.mem_req), 32'd0);
    tick();
    clr = 1'b0;
    tick();
    chk("ar_mar", 32'(bus_if.mem_addr), 32'h0);
    chk("ar_mdr", bus_if.BusMuxIn_MDR, 32'h0);
    chk("ar_busy", 32'(bus_if.busy), 32'd0);
    chk("ar_err", 32'(bus_if.err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
